// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Elastic DMA-to-DAC FIFO: primes to PREFILL_LEVEL, then delivers one word per clock.
// Optional macro DAC_DMA_FIFO_UNF_HOLD_EN repeats the last RUN word during underflow recovery.
module ad_ip_jesd204_tpl_dac_dma_fifo #(
  parameter int NUM_CHANNELS    = 1,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PREFILL_LEVEL   = 8
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] s_data,
  input  logic                                                   s_valid,
  output logic                                                   s_ready,
  input  logic                                                   dac_enable,
  input  logic                                                   dac_data_sync,
  output logic [NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] dma_data,
  output logic                                                   dac_dunf,
  input  logic                                                   dac_dunf_clr,
  output logic [1:0]                                             dbg_state,  // 0 IDLE, 1 PREFILL, 2 RUN
  output logic [FIFO_ADDR_WIDTH:0]                               dbg_level
);

  localparam int W     = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE;
  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] PREFILL_LVL = (AW+1)'(PREFILL_LEVEL);

  typedef enum logic [1:0] {IDLE = 2'd0, PREFILL = 2'd1, RUN = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level, level_push;
  logic          flush, push, pop, unf, hold_active;

  // Handshake: a word moves when s_valid && s_ready on a rising clk edge. s_ready is a
  // function of registered state only; s_valid may be raised or dropped at any time.
  always_comb begin
    flush      = !dac_enable || dac_data_sync;
    push       = s_valid && s_ready && !flush;
    pop        = (state == RUN) && (level != '0) && !flush;
    // A push landing at level 0 cannot be popped the same cycle, so it is a bubble, not an underflow.
    unf        = (state == RUN) && (level == '0) && !push && !flush;
    level_push = level + (AW+1)'(push);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dac_enable) state_nxt = PREFILL;
      PREFILL: if (level_push >= PREFILL_LVL) state_nxt = RUN;
      RUN:     if (unf) state_nxt = PREFILL;
      default: state_nxt = IDLE;
    endcase
    if (!dac_enable) begin
      state_nxt = IDLE;
    end else if (dac_data_sync) begin
      state_nxt = PREFILL;
    end
  end

  always_comb begin
    s_ready   = (state != IDLE) && (level < FULL_LVL);
    dbg_state = state;
    dbg_level = level;
  end

`ifdef DAC_DMA_FIFO_UNF_HOLD_EN
  logic hold_q;

  // Remembers that PREFILL was entered through an underflow, until data streams again.
  always_ff @(posedge clk) begin
    if (reset || flush || pop) begin
      hold_q <= 1'b0;
    end else if (unf) begin
      hold_q <= 1'b1;
    end
  end

  assign hold_active = unf || hold_q;
`else
  assign hold_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // dma_data doubles as the RAM read register.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dma_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_push - (AW+1)'(pop);
      if (pop) begin
        dma_data <= mem[rd_ptr];
      end else if (!hold_active) begin
        dma_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dac_dunf <= 1'b0;
    end else if (unf) begin
      dac_dunf <= 1'b1;
    end else if (dac_dunf_clr) begin
      dac_dunf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Bench for ad_ip_jesd204_tpl_dac_dma_fifo: vector table, corner sequences, and a
// queue-based reference model driven with random traffic.
module tb_ad_ip_jesd204_tpl_dac_dma_fifo;

  localparam int W = 64;

`ifdef DAC_DMA_FIFO_UNF_HOLD_EN
  localparam bit HOLD_BUILD = 1'b1;
`else
  localparam bit HOLD_BUILD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         dac_enable = 1'b0;
  logic         dac_data_sync = 1'b0;
  logic [W-1:0] dma_data;
  logic         dac_dunf;
  logic         dac_dunf_clr = 1'b0;
  logic [1:0]   dbg_state;
  logic [4:0]   dbg_level;

  ad_ip_jesd204_tpl_dac_dma_fifo u_dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dac_enable(dac_enable), .dac_data_sync(dac_data_sync), .dma_data(dma_data),
    .dac_dunf(dac_dunf), .dac_dunf_clr(dac_dunf_clr), .dbg_state(dbg_state), .dbg_level(dbg_level)
  );

  // Second instance primed to the full depth, for backpressure.
  logic         f_reset = 1'b1;
  logic [W-1:0] f_data = '0;
  logic         f_valid = 1'b0;
  logic         f_ready;
  logic         f_en = 1'b0;
  logic         f_sync = 1'b0;
  logic         f_clr = 1'b0;
  logic [W-1:0] f_dma;
  logic         f_dunf;
  logic [1:0]   f_state;
  logic [4:0]   f_level;

  ad_ip_jesd204_tpl_dac_dma_fifo #(.PREFILL_LEVEL(16)) u_full (
    .clk(clk), .reset(f_reset), .s_data(f_data), .s_valid(f_valid), .s_ready(f_ready),
    .dac_enable(f_en), .dac_data_sync(f_sync), .dma_data(f_dma),
    .dac_dunf(f_dunf), .dac_dunf_clr(f_clr), .dbg_state(f_state), .dbg_level(f_level)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode 0 idle, 1 priming, 2 streaming; the FIFO contents are just a queue.
  int           m_mode = 0;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_out = '0;
  bit           m_dunf = 1'b0;
  bit           m_hold = 1'b0;

  task automatic model_step(input bit r, en, v, input logic [W-1:0] d, input bit sy, cl);
    bit ready;
    bit push;
    bit unf;
    ready = (m_mode != 0) && (m_q.size() < 16);
    push  = v && ready;
    unf   = 1'b0;
    if (r) begin
      m_mode = 0; m_q.delete(); m_out = '0; m_dunf = 1'b0; m_hold = 1'b0;
    end else begin
      if (!en) begin
        m_mode = 0; m_q.delete(); m_out = '0; m_hold = 1'b0;
      end else if (sy) begin
        m_mode = 1; m_q.delete(); m_out = '0; m_hold = 1'b0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_out = '0;
      end else if (m_mode == 1) begin
        if (push) m_q.push_back(d);
        if (m_q.size() >= 8) m_mode = 2;
        if (!(HOLD_BUILD && m_hold)) m_out = '0;
      end else begin
        if (m_q.size() > 0) begin
          m_out  = m_q.pop_front();
          m_hold = 1'b0;
          if (push) m_q.push_back(d);
        end else if (push) begin
          m_q.push_back(d);
          m_out = '0;
        end else begin
          unf    = 1'b1;
          m_mode = 1;
          m_hold = 1'b1;
          if (!HOLD_BUILD) m_out = '0;
        end
      end
      if (unf) m_dunf = 1'b1;
      else if (cl) m_dunf = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit r, en, v, input logic [W-1:0] d, input bit sy, cl);
    reset = r; dac_enable = en; s_valid = v; s_data = d; dac_data_sync = sy; dac_dunf_clr = cl;
    model_step(r, en, v, d, sy, cl);
    @(posedge clk);
    #1;
    check("dma_data", dma_data, m_out);
    check("s_ready", 64'(s_ready), 64'((m_mode != 0) && (m_q.size() < 16)));
    check("dac_dunf", 64'(dac_dunf), 64'(m_dunf));
    check("state", 64'(dbg_state), 64'(m_mode));
    check("level", 64'(dbg_level), 64'(m_q.size()));
  endtask

  typedef struct {
    bit           rst, en, v, sy, cl;
    logic [W-1:0] d;
    bit           e_ready, e_dunf;
    logic [W-1:0] e_data;
    logic [1:0]   e_state;
    logic [4:0]   e_level;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(bit rst, en, v, logic [W-1:0] d, bit e_ready,
                              logic [W-1:0] e_data, logic [1:0] e_state, logic [4:0] e_level);
    vec_t t;
    t.rst = rst; t.en = en; t.v = v; t.d = d; t.sy = 1'b0; t.cl = 1'b0;
    t.e_ready = e_ready; t.e_dunf = 1'b0; t.e_data = e_data; t.e_state = e_state; t.e_level = e_level;
    return t;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           f_run;
    bit           acc;
    bit           got_unf;
    bit           will_unf;
    int           n_acc;
    int           p_valid;
    bit           r, en, v, sy, cl;
    logic [W-1:0] d;

    // Vectors: reset, enable, eight primes, then streaming with pushes continuing.
    vecs[0] = mk(1, 0, 0, 64'h0, 0, 64'h0, 2'd0, 5'd0);
    vecs[1] = mk(0, 1, 0, 64'h0, 1, 64'h0, 2'd1, 5'd0);
    for (int k = 1; k <= 8; k++)
      vecs[k+1] = mk(0, 1, 1, 64'(k), 1, 64'h0, (k < 8) ? 2'd1 : 2'd2, 5'(k));
    vecs[10] = mk(0, 1, 1, 64'h9,    1, 64'h1, 2'd2, 5'd8);
    vecs[11] = mk(0, 1, 1, 64'ha,    1, 64'h2, 2'd2, 5'd8);
    vecs[12] = mk(0, 1, 1, 64'habcd, 1, 64'h3, 2'd2, 5'd8);

    // ---- full backpressure on the deep-prefill instance (main DUT held in reset) ----
    @(posedge clk); #1;
    f_reset = 1'b0; f_en = 1'b1; f_valid = 1'b1; f_data = 64'h1;
    f_run = 1'b0; n_acc = 0;
    for (int c = 0; c < 40 && !f_run; c++) begin
      acc = f_ready;
      @(posedge clk); #1;
      if (acc) begin exp_q.push_back(f_data); f_data = f_data + 64'h1; n_acc++; end
      if (f_state == 2'd2) f_run = 1'b1;
    end
    check("full_run_reached", 64'(f_run), 64'(1));
    check("full_accepts", 64'(n_acc), 64'(16));
    check("full_ready_low", 64'(f_ready), 64'(0));
    check("full_level", 64'(f_level), 64'(16));
    for (int c = 0; c < 16; c++) begin
      acc = f_ready;
      @(posedge clk); #1;
      if (acc) begin exp_q.push_back(f_data); f_data = f_data + 64'h1; end
      if (exp_q.size() == 0) check("full_order_empty", 64'(1), 64'(0));
      else check("full_order", f_dma, exp_q.pop_front());
    end
    check("full_no_unf", 64'(f_dunf), 64'(0));
    f_en = 1'b0; f_valid = 1'b0;

    // ---- vector table: prefill and stream ----
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].v, vecs[i].d, vecs[i].sy, vecs[i].cl);
      check($sformatf("vec%0d_ready", i), 64'(s_ready), 64'(vecs[i].e_ready));
      check($sformatf("vec%0d_data", i), dma_data, vecs[i].e_data);
      check($sformatf("vec%0d_dunf", i), 64'(dac_dunf), 64'(vecs[i].e_dunf));
      check($sformatf("vec%0d_state", i), 64'(dbg_state), 64'(vecs[i].e_state));
      check($sformatf("vec%0d_level", i), 64'(dbg_level), 64'(vecs[i].e_level));
    end

    // ---- underflow: drain to 3 words, then three words, then the underflow ----
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 64'h0, 0, 0);
    check("unf_level3", 64'(dbg_level), 64'(3));
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 64'h0, 0, 0);
      check("unf_word_valid", 64'(dma_data != '0), 64'(1));
    end
    check("unf_last_word", dma_data, 64'habcd);
    cycle(0, 1, 0, 64'h0, 0, 0);
    check("unf_flag", 64'(dac_dunf), 64'(1));
    check("unf_data", dma_data, HOLD_BUILD ? 64'habcd : 64'h0);
    check("unf_state", 64'(dbg_state), 64'(1));
    cycle(0, 1, 0, 64'h0, 0, 1);
    check("clr_flag", 64'(dac_dunf), 64'(0));
    check("prefill_hold_data", dma_data, HOLD_BUILD ? 64'habcd : 64'h0);

    // ---- clear colliding with a fresh underflow: set wins ----
    for (int k = 0; k < 8; k++) cycle(0, 1, 1, 64'h300 + 64'(k), 0, 0);
    check("reprime_state", 64'(dbg_state), 64'(2));
    got_unf = 1'b0;
    for (int k = 0; k < 30 && !got_unf; k++) begin
      will_unf = (m_mode == 2) && (m_q.size() == 0);
      cycle(0, 1, 0, 64'h0, 0, will_unf);
      if (will_unf) begin
        got_unf = 1'b1;
        check("clr_vs_set_dunf", 64'(dac_dunf), 64'(1));
      end
    end
    check("clr_vs_set_reached", 64'(got_unf), 64'(1));

    // ---- sync flush mid-RUN with 5 queued, alongside a push ----
    for (int k = 0; k < 8; k++) cycle(0, 1, 1, 64'h100 + 64'(k), 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 64'h0, 0, 0);
    check("sync_pre_level", 64'(dbg_level), 64'(5));
    cycle(0, 1, 1, 64'hdead, 1, 0);
    check("sync_level", 64'(dbg_level), 64'(0));
    check("sync_data", dma_data, 64'h0);
    check("sync_state", 64'(dbg_state), 64'(1));
    for (int k = 0; k < 8; k++) cycle(0, 1, 1, 64'h200 + 64'(k), 0, 0);
    cycle(0, 1, 0, 64'h0, 0, 0);
    check("sync_first_new", dma_data, 64'h200);

    // ---- disable mid-RUN ----
    cycle(0, 0, 1, 64'h55, 0, 0);
    check("dis_data", dma_data, 64'h0);
    check("dis_ready", 64'(s_ready), 64'(0));
    check("dis_level", 64'(dbg_level), 64'(0));
    check("dis_dunf_kept", 64'(dac_dunf), 64'(1));

    // ---- reset mid-RUN with every other input active ----
    cycle(0, 1, 0, 64'h0, 0, 0);
    for (int k = 0; k < 10; k++) cycle(0, 1, 1, 64'h400 + 64'(k), 0, 0);
    cycle(1, 1, 1, 64'h77, 1, 1);
    check("rst_data", dma_data, 64'h0);
    check("rst_ready", 64'(s_ready), 64'(0));
    check("rst_dunf", 64'(dac_dunf), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    check("rst_level", 64'(dbg_level), 64'(0));

    // ---- randomized traffic against the model ----
    p_valid = 100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) p_valid = $urandom_range(30, 100);
      r  = ($urandom_range(0, 999) == 0);
      en = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(1, 100) <= p_valid);
      d  = {$urandom, $urandom};
      sy = ($urandom_range(0, 149) == 0);
      cl = ($urandom_range(0, 29) == 0);
      cycle(r, en, v, d, sy, cl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
